// File: rtl/mem_access_pkg.sv
// Shared pipeline definitions for the memory stage: memory-op encoding,
// access sizes, control-word bit positions and small decode helpers.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LBU  = 4'd2,
    MOP_LH   = 4'd3,
    MOP_LHU  = 4'd4,
    MOP_LW   = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } ma_state_t;

  localparam logic [1:0] MSIZE_B = 2'd0;
  localparam logic [1:0] MSIZE_H = 2'd1;
  localparam logic [1:0] MSIZE_W = 2'd2;

  localparam int CTL_WE       = 15;
  localparam int CTL_MEMTOREG = 1;

  function automatic logic is_store(input mem_op_t op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

  function automatic logic [1:0] op_size(input mem_op_t op);
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: return MSIZE_B;
      MOP_LH, MOP_LHU, MOP_SH: return MSIZE_H;
      default:                 return MSIZE_W;
    endcase
  endfunction

  // Forces the low address bits to zero for the access width of op.
  function automatic logic [31:0] align_addr(input mem_op_t op, input logic [31:0] addr);
    case (op_size(op))
      MSIZE_H: return {addr[31:1], 1'b0};
      MSIZE_W: return {addr[31:2], 2'b00};
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_format.sv
// Combinational lane formatting: store strobes/replicated data, little-endian
// load extraction with sign/zero extension, and alignment checking.
module mem_format
  import mem_access_pkg::*;
(
  input  logic [3:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  strobe,
  output logic [31:0] lane_data,
  output logic [31:0] load_value,
  output logic        misalign
);

  mem_op_t     op;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign op       = mem_op_t'(mem_op);
  assign byte_sel = read_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? read_word[31:16] : read_word[15:0];

  always_comb begin
    strobe     = 4'b0000;
    lane_data  = 32'h0;
    load_value = 32'h0;
    misalign   = 1'b0;
    case (op)
      MOP_LB:  load_value = {{24{byte_sel[7]}}, byte_sel};
      MOP_LBU: load_value = {24'h0, byte_sel};
      MOP_LH: begin
        load_value = {{16{half_sel[15]}}, half_sel};
        misalign   = addr_lo[0];
      end
      MOP_LHU: begin
        load_value = {16'h0, half_sel};
        misalign   = addr_lo[0];
      end
      MOP_LW: begin
        load_value = read_word;
        misalign   = |addr_lo;
      end
      MOP_SB: begin
        strobe    = 4'b0001 << addr_lo;
        lane_data = {4{store_data[7:0]}};
      end
      MOP_SH: begin
        strobe    = 4'b0011 << {addr_lo[1], 1'b0};
        lane_data = {2{store_data[15:0]}};
        misalign  = addr_lo[0];
      end
      MOP_SW: begin
        strobe    = 4'hF;
        lane_data = store_data;
        misalign  = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS memory stage: accepts one instruction from execute, performs any
// load/store over the request/response bus and presents registered results.
module mem_access
  import mem_access_pkg::*;
#(
  parameter bit STRICT_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] controlE,
  input  logic [3:0]  mem_opE,
  input  logic [4:0]  rdE,
  input  logic [31:0] ALUoutE,
  input  logic [31:0] WriteDataE,
  output logic        dreq_valid,
  output logic        dreq_write,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic [15:0] controlM,
  output logic [4:0]  rdM,
  output logic [31:0] ALUoutM,
  output logic [31:0] ReadDataM,
  output logic        out_valid,
  output logic        adel,
  output logic        ades
);

  ma_state_t   state;
  mem_op_t     op_q;
  mem_op_t     op_in;
  logic [31:0] addr_in;
  logic        reject;
  logic [15:0] ctl_fwd;

  logic [3:0]  fmt_op;
  logic [1:0]  fmt_addr;
  logic [3:0]  fmt_strobe;
  logic [31:0] fmt_lane;
  logic [31:0] fmt_load;
  logic        fmt_misalign;

  assign in_ready = (state == ST_IDLE);
  assign op_in    = mem_op_t'(mem_opE);
  assign addr_in  = STRICT_ALIGN ? ALUoutE : align_addr(op_in, ALUoutE);
  assign reject   = STRICT_ALIGN && fmt_misalign;

  // A rejected misaligned access must never reach the register file.
  always_comb begin
    ctl_fwd = controlE;
    if (reject) ctl_fwd[CTL_WE] = 1'b0;
  end

  // The formatter sees the incoming op while idle and the held request otherwise.
  assign fmt_op   = (state == ST_IDLE) ? op_in : op_q;
  assign fmt_addr = (state == ST_IDLE) ? addr_in[1:0] : dreq_addr[1:0];

  mem_format u_format (
    .mem_op     (fmt_op),
    .addr_lo    (fmt_addr),
    .store_data (WriteDataE),
    .read_word  (dresp_data),
    .strobe     (fmt_strobe),
    .lane_data  (fmt_lane),
    .load_value (fmt_load),
    .misalign   (fmt_misalign)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      op_q        <= MOP_NONE;
      dreq_valid  <= 1'b0;
      dreq_write  <= 1'b0;
      dreq_addr   <= 32'h0;
      dreq_size   <= MSIZE_B;
      dreq_strobe <= 4'b0000;
      dreq_data   <= 32'h0;
      controlM    <= 16'h0;
      rdM         <= 5'd0;
      ALUoutM     <= 32'h0;
      ReadDataM   <= 32'h0;
      out_valid   <= 1'b0;
      adel        <= 1'b0;
      ades        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            op_q      <= op_in;
            controlM  <= ctl_fwd;
            rdM       <= rdE;
            ALUoutM   <= ALUoutE;
            ReadDataM <= 32'h0;
            adel      <= reject && !is_store(op_in);
            ades      <= reject && is_store(op_in);
            if (op_in == MOP_NONE || reject) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              state       <= ST_REQ;
              dreq_valid  <= 1'b1;
              dreq_write  <= is_store(op_in);
              dreq_addr   <= addr_in;
              dreq_size   <= op_size(op_in);
              dreq_strobe <= fmt_strobe;
              dreq_data   <= fmt_lane;
            end
          end
        end
        ST_REQ: begin
          if (dresp_addr_ok) begin
            dreq_valid <= 1'b0;
            if (dresp_data_ok) begin
              ReadDataM <= fmt_load;
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dresp_data_ok) begin
            ReadDataM <= fmt_load;
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with STRICT_ALIGN = 1:
// pass-through, loads with both handshake timings, stores, misalignment, reset.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] controlE;
  logic [3:0]  mem_opE;
  logic [4:0]  rdE;
  logic [31:0] ALUoutE;
  logic [31:0] WriteDataE;
  logic        dreq_valid;
  logic        dreq_write;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic [15:0] controlM;
  logic [4:0]  rdM;
  logic [31:0] ALUoutM;
  logic [31:0] ReadDataM;
  logic        out_valid;
  logic        adel;
  logic        ades;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access #(.STRICT_ALIGN(1'b1)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .controlE      (controlE),
    .mem_opE       (mem_opE),
    .rdE           (rdE),
    .ALUoutE       (ALUoutE),
    .WriteDataE    (WriteDataE),
    .dreq_valid    (dreq_valid),
    .dreq_write    (dreq_write),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .controlM      (controlM),
    .rdM           (rdM),
    .ALUoutM       (ALUoutM),
    .ReadDataM     (ReadDataM),
    .out_valid     (out_valid),
    .adel          (adel),
    .ades          (ades)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input logic [15:0] ctl);
    in_valid   = 1'b1;
    mem_opE    = op;
    ALUoutE    = addr;
    WriteDataE = wdata;
    rdE        = rd;
    controlE   = ctl;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  initial begin
    resetn        = 1'b0;
    in_valid      = 1'b0;
    controlE      = 16'h0;
    mem_opE       = MOP_NONE;
    rdE           = 5'd0;
    ALUoutE       = 32'h0;
    WriteDataE    = 32'h0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("rst_controlM", {16'h0, controlM}, 32'h0);
    checkOutput("rst_rdM", {27'h0, rdM}, 32'h0);
    checkOutput("rst_ALUoutM", ALUoutM, 32'h0);
    checkOutput("rst_ReadDataM", ReadDataM, 32'h0);
    checkOutput("rst_adel_ades", {30'h0, adel, ades}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Non-memory pass-through, latency 1
    applyStimulus(MOP_NONE, 32'h1234_5678, 32'h0, 5'd5, 16'h8000);
    checkOutput("none_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("none_ALUoutM", ALUoutM, 32'h1234_5678);
    checkOutput("none_rdM", {27'h0, rdM}, 32'd5);
    checkOutput("none_controlM", {16'h0, controlM}, 32'h8000);
    checkOutput("none_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    checkOutput("none_in_ready_done", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    checkOutput("none_pulse_end", {31'h0, out_valid}, 32'h0);
    checkOutput("none_dreq_after", {31'h0, dreq_valid}, 32'h0);
    checkOutput("none_in_ready_idle", {31'h0, in_ready}, 32'h1);

    // LB at 0x1003: addr_ok after one request cycle, data_ok two cycles later
    applyStimulus(MOP_LB, 32'h0000_1003, 32'h0, 5'd8, 16'h8002);
    checkOutput("lb_dreq_valid", {31'h0, dreq_valid}, 32'h1);
    checkOutput("lb_dreq_addr", dreq_addr, 32'h0000_1003);
    checkOutput("lb_dreq_size", {30'h0, dreq_size}, 32'd0);
    checkOutput("lb_dreq_write", {31'h0, dreq_write}, 32'h0);
    checkOutput("lb_dreq_strobe", {28'h0, dreq_strobe}, 32'h0);
    checkOutput("lb_in_ready_req", {31'h0, in_ready}, 32'h0);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    checkOutput("lb_wait_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    checkOutput("lb_wait_in_ready", {31'h0, in_ready}, 32'h0);
    checkOutput("lb_wait_out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    checkOutput("lb_wait2_out_valid", {31'h0, out_valid}, 32'h0);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'h80FF_0011;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    dresp_data    = 32'hDEAD_BEEF;
    checkOutput("lb_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("lb_ReadDataM", ReadDataM, 32'hFFFF_FF80);
    checkOutput("lb_in_ready_done", {31'h0, in_ready}, 32'h0);
    checkOutput("lb_rdM", {27'h0, rdM}, 32'd8);
    @(negedge clk);
    checkOutput("lb_single_pulse", {31'h0, out_valid}, 32'h0);

    // LHU at 0x2002 with addr_ok and data_ok together
    applyStimulus(MOP_LHU, 32'h0000_2002, 32'h0, 5'd9, 16'h8002);
    checkOutput("lhu_dreq_size", {30'h0, dreq_size}, 32'd1);
    checkOutput("lhu_early_out_valid", {31'h0, out_valid}, 32'h0);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = 32'hBEEF_0000;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 32'hDEAD_BEEF;
    checkOutput("lhu_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("lhu_ReadDataM", ReadDataM, 32'h0000_BEEF);
    checkOutput("lhu_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    @(negedge clk);

    // SB at 0x3001, request held through three stalled cycles
    applyStimulus(MOP_SB, 32'h0000_3001, 32'h0000_00AB, 5'd0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sb_hold%0d_valid", i), {31'h0, dreq_valid}, 32'h1);
      checkOutput($sformatf("sb_hold%0d_strobe", i), {28'h0, dreq_strobe}, 32'h2);
      checkOutput($sformatf("sb_hold%0d_data", i), dreq_data, 32'hABAB_ABAB);
      checkOutput($sformatf("sb_hold%0d_write", i), {31'h0, dreq_write}, 32'h1);
      checkOutput($sformatf("sb_hold%0d_addr", i), dreq_addr, 32'h0000_3001);
      if (i == 2) dresp_addr_ok = 1'b1;
      @(negedge clk);
    end
    dresp_addr_ok = 1'b0;
    checkOutput("sb_accepted", {31'h0, dreq_valid}, 32'h0);
    dresp_data_ok = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    checkOutput("sb_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("sb_ReadDataM", ReadDataM, 32'h0);
    checkOutput("sb_ades", {31'h0, ades}, 32'h0);
    @(negedge clk);

    // Misaligned LW at 0x4002: no bus access, adel, write enable dropped
    applyStimulus(MOP_LW, 32'h0000_4002, 32'h0, 5'd3, 16'h8002);
    checkOutput("lw_mis_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("lw_mis_adel", {31'h0, adel}, 32'h1);
    checkOutput("lw_mis_ades", {31'h0, ades}, 32'h0);
    checkOutput("lw_mis_controlM", {16'h0, controlM}, 32'h0002);
    checkOutput("lw_mis_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    @(negedge clk);

    // Misaligned SH at 0x5001 raises ades
    applyStimulus(MOP_SH, 32'h0000_5001, 32'h0000_1234, 5'd0, 16'h8000);
    checkOutput("sh_mis_ades", {31'h0, ades}, 32'h1);
    checkOutput("sh_mis_adel", {31'h0, adel}, 32'h0);
    checkOutput("sh_mis_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    @(negedge clk);

    // Reset while a request is pending drops dreq_valid at once
    applyStimulus(MOP_LW, 32'h0000_6000, 32'h0, 5'd4, 16'h8002);
    checkOutput("rstreq_pre_valid", {31'h0, dreq_valid}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rstreq_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    checkOutput("rstreq_out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset while waiting for data; a late data_ok must be ignored
    applyStimulus(MOP_LW, 32'h0000_7000, 32'h0, 5'd4, 16'h8002);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checkOutput("rstwait_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    checkOutput("rstwait_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rstwait_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    resetn        = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    dresp_addr_ok = 1'b0;
    checkOutput("late_ok_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("late_ok_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("late_ok_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    applyStimulus(MOP_NONE, 32'hCAFE_0001, 32'h0, 5'd7, 16'h8000);
    checkOutput("post_rst_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("post_rst_rdM", {27'h0, rdM}, 32'd7);
    checkOutput("post_rst_ALUoutM", ALUoutM, 32'hCAFE_0001);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
